fht_io_sched: RTL and testbench
===============================

Name: fht_io_sched

Overview:
- Host-side frame scheduler for the 1024-point FHT core.
- Streams one frame of input samples into the four 256-word data banks in bit-reversed order.
- Hands the banks to the FHT core via a start pulse, waits for the core's ready, then streams the results out in natural order with valid/ready backpressure.
- Owns the bank-port select between host and core, so load, compute and unload never overlap.

Parameters:
- A_BIT, 8, bank address width (256 words per bank).
- D_BIT, 16, sample width.
- N_LOG, 10, log2 of frame length; frame length N = 2^N_LOG = 4 * 2^A_BIT.

Ports:
- iCLK  in  1  single system clock.
- iRESET  in  1  asynchronous, active-low reset.
- iDATA  in  D_BIT  input sample.
- iVALID  in  1  input sample valid.
- oREADY  out  1  scheduler accepts the input sample this cycle.
- oCORE_START  out  1  one-cycle start pulse to the FHT core.
- iCORE_RDY  in  1  core ready/idle flag (high when idle).
- oOWN_CORE  out  1  bank-port select: 1 = core owns the banks, 0 = scheduler owns them.
- oWE  out  4  per-bank write enable, one-hot.
- oADDR_WR  out  A_BIT  bank write address.
- oDATA_WR  out  D_BIT  bank write data.
- oBANK_RD  out  2  bank select for the read mux.
- oADDR_RD  out  A_BIT  bank read address.
- iDATA_RD  in  D_BIT  muxed bank read data; valid exactly 1 cycle after the address.
- oDATA  out  D_BIT  output sample.
- oVALID  out  1  output sample valid.
- iREADY  in  1  downstream accepts the output sample.
- oBUSY  out  1  high in every state except LOAD.

Behaviour:
- Reset (iRESET low, asynchronous) puts the block in state LOAD with all counters at 0. Output reset values:
  - oREADY=1, oCORE_START=0, oOWN_CORE=0, oWE=0, oADDR_WR=0, oDATA_WR=0.
  - oBANK_RD=0, oADDR_RD=0, oVALID=0, oDATA=0, oBUSY=0.
  - Output buffer empty.
- States: LOAD -> START -> WAIT_LOW -> RUN -> UNLOAD -> LOAD.
- LOAD:
  - oREADY=1; a sample is accepted when iVALID & oREADY.
  - For input index k (10-bit counter cnt_in), let r = bitrev10(k). Write to bank r[1:0] at address r[9:2].
  - Write is registered: oWE/oADDR_WR/oDATA_WR are asserted in the cycle after acceptance, for exactly one cycle.
  - Gaps on iVALID hold cnt_in.
  - The accept at k=1023 moves to START; oREADY drops in the next cycle.
- START:
  - oCORE_START=1 for exactly one cycle; oOWN_CORE=1 from this state through RUN.
  - The last write (k=1023) completes in the START cycle, before the core's first read.
- WAIT_LOW: stays until iCORE_RDY=0, then goes to RUN. iCORE_RDY still high after 4 cycles is a core fault: stay in WAIT_LOW; covered by assertion only.
- RUN: stays until iCORE_RDY=1, then goes to UNLOAD. oOWN_CORE drops on entry to UNLOAD.
- UNLOAD:
  - Read index j (cnt_rd) maps to oBANK_RD = j[1:0], oADDR_RD = j[9:2], natural order.
  - Read issue condition: (buf_cnt + inflight - pop) < 2, where pop = oVALID & iREADY.
  - Read data is captured into a 2-entry output buffer 1 cycle after issue; oVALID = buffer not empty; oDATA = buffer head.
  - With iREADY held high, the first oVALID appears 2 cycles after entering UNLOAD, then one sample per cycle with no bubbles.
  - With iREADY low, issue stops with the buffer full. No sample is lost or duplicated across any iREADY pattern.
  - After pop number 1024 (cnt_out wraps to 0): return to LOAD; oREADY=1 in the next cycle.
- Counters are 10-bit and wrap naturally at 1024.
- The transition is decided by the final count, never by overflow flags.
- oCORE_START is never reasserted until a full new frame is loaded.
- Async reset at any point, including mid-RUN, returns to LOAD and clears the buffer. The core's own reset is separate; the scheduler ignores iCORE_RDY while in LOAD.

Test Plan:
1. Continuous iVALID, samples k=0..1023 with data=k:
   - k=1 -> oWE=0001 at addr 128.
   - k=2 -> bank0 addr 64.
   - k=512 -> oWE=0010 at addr 0.
   - k=1023 -> oWE=1000 at addr 255.
   - Exactly 1024 writes in total.
2. Start handshake: oCORE_START is high exactly 1 cycle, 1 cycle after the last accept. Model core drops iCORE_RDY next cycle, raises it 2600 cycles later -> oOWN_CORE high exactly over START..RUN, UNLOAD entered 1 cycle after iCORE_RDY rises.
3. Unload with iREADY=1 and banks preloaded with bank*1000+addr:
   - Outputs 0, 1000, 2000, 3000, 1, 1001, ...
   - 1024 consecutive valid cycles, no gaps after the first.
4. Unload with random iREADY (50%) plus iREADY held low for 20 cycles:
   - Output sequence identical to scenario 3.
   - Buffer never exceeds 2 entries; exactly 1024 handshakes.
5. iVALID toggling every other cycle during LOAD -> writes occur only after accepts, cnt_in holds during gaps, START is reached after exactly 1024 accepts.
6. Reset asserted mid-UNLOAD (after 300 outputs) -> oVALID=0 immediately, oREADY=1. A new frame then loads and completes normally.

Source files
------------

// File: rtl/fht_io_sched.sv
// Host-side frame scheduler for the 1024-point FHT: bit-reversed bank load, core handoff, natural-order unload.
// Latency: bank write 1 cycle after accept; first output 2 cycles after unload begins, then 1 sample/cycle.
// Backpressure: oREADY only in LOAD; unload reads stall while the 2-entry output buffer would overflow.
module fht_io_sched #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16,
    parameter int N_LOG = 10
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic             oCORE_START,
    input  logic             iCORE_RDY,
    output logic             oOWN_CORE,
    output logic [3:0]       oWE,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA_WR,
    output logic [1:0]       oBANK_RD,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iDATA_RD,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oBUSY
);

    typedef enum logic [2:0] {S_LOAD, S_START, S_WAIT_LOW, S_RUN, S_UNLOAD} state_t;

    state_t           state, state_nxt;
    logic [N_LOG-1:0] cnt_in, cnt_rd, cnt_out, rev_in;
    logic             accept, issue, pop, inflight, rd_done;
    logic [1:0]       buf_cnt;
    logic [2:0]       occ_nxt;
    logic             buf_wp, buf_rp;
    logic [D_BIT-1:0] buf_mem [2];
    logic [2:0]       wait_cnt;

    assign oREADY   = (state == S_LOAD);
    assign oBUSY    = (state != S_LOAD);
    assign accept   = iVALID & oREADY;
    assign oVALID   = (buf_cnt != 2'd0);
    assign oDATA    = buf_mem[buf_rp];
    assign pop      = oVALID & iREADY;
    assign oBANK_RD = cnt_rd[1:0];
    assign oADDR_RD = cnt_rd[N_LOG-1:2];

    // Occupancy the buffer will have once this cycle's pop is taken; keeps at most 2 entries committed.
    assign occ_nxt = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = (state == S_UNLOAD) && !rd_done && (occ_nxt < 3'd2);

    always_comb begin
        rev_in = '0;
        for (int i = 0; i < N_LOG; i++) begin
            rev_in[i] = cnt_in[N_LOG-1-i];
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        oCORE_START = 1'b0;
        oOWN_CORE   = 1'b0;
        unique case (state)
            S_LOAD: begin
                if (accept && cnt_in == '1) state_nxt = S_START;
            end
            S_START: begin
                oCORE_START = 1'b1;
                oOWN_CORE   = 1'b1;
                state_nxt   = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                oOWN_CORE = 1'b1;
                if (!iCORE_RDY) state_nxt = S_RUN;
            end
            S_RUN: begin
                oOWN_CORE = 1'b1;
                if (iCORE_RDY) state_nxt = S_UNLOAD;
            end
            S_UNLOAD: begin
                if (pop && cnt_out == '1) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Sample k lands in bank r[1:0], word r[9:2] with r = bitrev(k); the write is registered.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cnt_in   <= '0;
            oWE      <= '0;
            oADDR_WR <= '0;
            oDATA_WR <= '0;
        end else begin
            oWE <= '0;
            if (accept) begin
                oWE      <= 4'b0001 << rev_in[1:0];
                oADDR_WR <= rev_in[N_LOG-1:2];
                oDATA_WR <= iDATA;
                cnt_in   <= cnt_in + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cnt_rd     <= '0;
            cnt_out    <= '0;
            rd_done    <= 1'b0;
            inflight   <= 1'b0;
            buf_cnt    <= '0;
            buf_wp     <= 1'b0;
            buf_rp     <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                cnt_rd <= cnt_rd + 1'b1;
                if (cnt_rd == '1) rd_done <= 1'b1;
            end
            if (inflight) begin
                buf_mem[buf_wp] <= iDATA_RD;
                buf_wp          <= ~buf_wp;
            end
            if (pop) begin
                buf_rp  <= ~buf_rp;
                cnt_out <= cnt_out + 1'b1;
                if (cnt_out == '1) rd_done <= 1'b0;
            end
            unique case ({inflight, pop})
                2'b10:   buf_cnt <= buf_cnt + 1'b1;
                2'b01:   buf_cnt <= buf_cnt - 1'b1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Cycles spent in WAIT_LOW with the core still reporting idle.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT_LOW) begin
            wait_cnt <= '0;
        end else if (iCORE_RDY && wait_cnt != 3'd7) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    a_core_ack: assert property (@(posedge iCLK) disable iff (!iRESET)
        !(state == S_WAIT_LOW && iCORE_RDY && wait_cnt >= 3'd4));
    a_buf_bound: assert property (@(posedge iCLK) disable iff (!iRESET) buf_cnt <= 2'd2);

endmodule

// File: tb/tb_fht_io_sched.sv
// Bench for fht_io_sched: directed frames against a bank RAM, a core stand-in and a frame-level reference model.
module tb_fht_io_sched;
    localparam int A_BIT = 8;
    localparam int D_BIT = 16;
    localparam int N_LOG = 10;
    localparam int N     = 1 << N_LOG;

    logic             iCLK = 1'b0;
    logic             iRESET = 1'b0;
    logic [D_BIT-1:0] iDATA = '0;
    logic             iVALID = 1'b0;
    logic             oREADY;
    logic             oCORE_START;
    logic             iCORE_RDY = 1'b1;
    logic             oOWN_CORE;
    logic [3:0]       oWE;
    logic [A_BIT-1:0] oADDR_WR;
    logic [D_BIT-1:0] oDATA_WR;
    logic [1:0]       oBANK_RD;
    logic [A_BIT-1:0] oADDR_RD;
    logic [D_BIT-1:0] iDATA_RD;
    logic [D_BIT-1:0] oDATA;
    logic             oVALID;
    logic             iREADY = 1'b0;
    logic             oBUSY;

    fht_io_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT), .N_LOG(N_LOG)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
        .oCORE_START(oCORE_START), .iCORE_RDY(iCORE_RDY), .oOWN_CORE(oOWN_CORE),
        .oWE(oWE), .oADDR_WR(oADDR_WR), .oDATA_WR(oDATA_WR),
        .oBANK_RD(oBANK_RD), .oADDR_RD(oADDR_RD), .iDATA_RD(iDATA_RD),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errs   = 0;

    // Four 256-word banks; read data appears one cycle after the address.
    logic [D_BIT-1:0] mem [4][256];
    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (oWE[b]) mem[b][oADDR_WR] <= oDATA_WR;
        end
        iDATA_RD <= mem[oBANK_RD][oADDR_RD];
    end

    // Frame-level model: 0 LOAD, 1 START, 2 WAIT_LOW, 3 RUN, 4 UNLOAD.
    int               m_phase = 0;
    int               m_acc = 0;
    int               m_unl_cyc = 0;
    int               m_out = 0;
    bit               m_wr_pend = 1'b0;
    logic [1:0]       m_wr_bank;
    logic [7:0]       m_wr_addr;
    logic [D_BIT-1:0] m_wr_data;
    bit               strict = 1'b0;
    int               dut_pops = 0;
    int               dut_writes = 0;
    logic [D_BIT-1:0] first_out [5];
    int               lit_first [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: bound expired without the awaited event (got none, expected one)", name);
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < N_LOG; i++) begin
            if ((k >> i) & 1) r = r | (1 << (N_LOG - 1 - i));
        end
        return r;
    endfunction

    // Core results are preloaded as bank*1000+addr, read back in natural order j -> bank j%4, addr j/4.
    function automatic int exp_out(input int j);
        return (j % 4) * 1000 + j / 4;
    endfunction

    initial begin
        int         r;
        logic [3:0] ew;
        forever begin
            @(negedge iCLK);
            if (!iRESET) begin
                m_phase   = 0;
                m_acc     = 0;
                m_unl_cyc = 0;
                m_out     = 0;
                m_wr_pend = 1'b0;
            end else begin
                chk("ctrl{ready,start,own,busy}", 32'({oREADY, oCORE_START, oOWN_CORE, oBUSY}),
                    32'({m_phase == 0, m_phase == 1, (m_phase >= 1 && m_phase <= 3), m_phase != 0}));
                ew = m_wr_pend ? (4'd1 << m_wr_bank) : 4'd0;
                chk("we", 32'(oWE), 32'(ew));
                if (m_wr_pend) chk("wr_addr_data", 32'({oADDR_WR, oDATA_WR}), 32'({m_wr_addr, m_wr_data}));
                if (oWE != 4'd0) dut_writes++;
                if (m_phase == 4) begin
                    if (strict) chk("valid_timing", 32'(oVALID), 32'(m_unl_cyc >= 2));
                    if (oVALID) chk("out_data", 32'(oDATA), 32'(exp_out(m_out)));
                end else begin
                    chk("valid_idle", 32'(oVALID), 32'd0);
                end
                if (oVALID && iREADY) begin
                    dut_pops++;
                    if (m_phase == 4 && m_out < 5) first_out[m_out] = oDATA;
                end
                m_wr_pend = 1'b0;
                case (m_phase)
                    0: if (iVALID) begin
                        r         = bitrev(m_acc);
                        m_wr_pend = 1'b1;
                        m_wr_bank = r[1:0];
                        m_wr_addr = r[9:2];
                        m_wr_data = iDATA;
                        m_acc++;
                        if (m_acc == N) begin
                            m_acc   = 0;
                            m_phase = 1;
                        end
                    end
                    1: m_phase = 2;
                    2: if (!iCORE_RDY) m_phase = 3;
                    3: if (iCORE_RDY) begin
                        m_phase   = 4;
                        m_unl_cyc = 0;
                        m_out     = 0;
                    end
                    default: begin
                        m_unl_cyc++;
                        if (oVALID && iREADY) begin
                            m_out++;
                            if (m_out == N) m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic chk_wr(input string name, input logic [3:0] we, input int addr);
        chk(name, 32'({oWE, oADDR_WR}), 32'({we, 8'(addr)}));
    endtask

    // Returns in the START cycle (the cycle after the final accept).
    task automatic load_frame(input int base, input bit gaps, input bit lit);
        dut_writes = 0;
        for (int k = 0; k < N; k++) begin
            @(posedge iCLK); #1;
            if (lit) begin
                case (k - 1)
                    1:       chk_wr("wr_k1", 4'b0001, 128);
                    2:       chk_wr("wr_k2", 4'b0001, 64);
                    512:     chk_wr("wr_k512", 4'b0010, 0);
                    default: ;
                endcase
            end
            iVALID = 1'b1;
            iDATA  = 16'(base + k);
            if (gaps) begin
                @(posedge iCLK); #1;
                iVALID = 1'b0;
            end
        end
        if (!gaps) begin
            @(posedge iCLK); #1;
            iVALID = 1'b0;
        end
        if (lit) begin
            chk_wr("wr_k1023", 4'b1000, 255);
            chk("start_after_last", 32'({oCORE_START, oREADY}), 32'b10);
        end
    endtask

    task automatic run_core(input int dur, input int base);
        int t = 0;
        int bad = 0;
        while (oCORE_START !== 1'b1 && t < 8) begin
            @(posedge iCLK); #1;
            t++;
        end
        if (t >= 8) fail_bound("core_start_wait");
        @(posedge iCLK); #1;
        iCORE_RDY = 1'b0;
        repeat (dur) @(posedge iCLK);
        #1;
        chk("frame_writes", 32'(dut_writes), 32'(N));
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 256; a++) begin
                if (mem[b][a] !== 16'(base + bitrev(a * 4 + b))) bad++;
            end
        end
        chk("bank_contents_bad_words", 32'(bad), 32'd0);
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 256; a++) mem[b][a] <= 16'(b * 1000 + a);
        end
        iCORE_RDY = 1'b1;
    endtask

    task automatic unload(input bit rnd, input int stop_at);
        int t = 0;
        int stall = 0;
        strict   = !rnd;
        iREADY   = 1'b1;
        dut_pops = 0;
        while (t < 6000) begin
            @(posedge iCLK); #1;
            t++;
            if (m_phase == 0) break;
            if (stop_at > 0 && m_out >= stop_at) break;
            if (rnd) begin
                if (m_out >= 400 && stall < 20) begin
                    iREADY = 1'b0;
                    stall++;
                end else begin
                    iREADY = 1'($urandom_range(0, 1));
                end
            end
        end
        if (t >= 6000) fail_bound("unload_done");
        else if (stop_at == 0) chk("frame_pops", 32'(dut_pops), 32'(N));
        iREADY = 1'b0;
        strict = 1'b0;
    endtask

    initial begin
        #1_000_000;
        fail_bound("watchdog");
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        lit_first = '{0, 1000, 2000, 3000, 1};
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_ready", 32'(oREADY), 32'd1);
        chk("rst_ctrl{start,own,valid,busy}", 32'({oCORE_START, oOWN_CORE, oVALID, oBUSY}), 32'd0);
        chk("rst_wr{we,addr,data}", 32'({oWE, oADDR_WR, oDATA_WR}), 32'd0);
        chk("rst_rd{bank,addr,data}", 32'({oBANK_RD, oADDR_RD, oDATA}), 32'd0);
        iRESET = 1'b1;

        // Continuous load, long core run, free-flowing unload.
        load_frame(0, 1'b0, 1'b1);
        run_core(2600, 0);
        unload(1'b0, 0);
        for (int i = 0; i < 5; i++) chk("first_out", 32'(first_out[i]), 32'(lit_first[i]));

        // Gapped load, random backpressure with a 20-cycle stall.
        load_frame(2048, 1'b1, 1'b0);
        run_core(40, 2048);
        unload(1'b1, 0);

        // Reset in the middle of unload, then a clean frame.
        load_frame(4096, 1'b0, 1'b0);
        run_core(40, 4096);
        unload(1'b0, 300);
        #2;
        iRESET = 1'b0;
        #1;
        chk("midrst_valid", 32'(oVALID), 32'd0);
        chk("midrst_ready", 32'(oREADY), 32'd1);
        chk("midrst{busy,own,start,we}", 32'({oBUSY, oOWN_CORE, oCORE_START, oWE}), 32'd0);
        @(posedge iCLK); #1;
        iRESET = 1'b1;

        load_frame(8192, 1'b0, 1'b0);
        run_core(40, 8192);
        unload(1'b0, 0);

        repeat (3) @(posedge iCLK);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
